// File: rtl/tensor_axi_pkg.sv
`default_nettype none
// ============================================================================
// tensor_axi_pkg : constants and types shared by the DDR load/dump AXI engines
// Rev 1.0
// ============================================================================
package tensor_axi_pkg;

  localparam int          BEATS_PER_ROW    = 8;
  localparam logic [31:0] ROW_STRIDE_BYTES = 32'h0000_0040;
  localparam logic [2:0]  AXI_SIZE_8B      = 3'b011;
  localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    AXI_AR     = 3'd1,
    AXI_R      = 3'd2,
    SRAM_WR    = 3'd3,
    CHECK_DONE = 3'd4
  } unpacker_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_beat_assembler.sv
`default_nettype none
// ============================================================================
// axi_beat_assembler : packs R-channel beats into one SRAM row, flags bad beats
// Rev 1.0
// ============================================================================
module axi_beat_assembler
  import tensor_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BEATS          = BEATS_PER_ROW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear_i,
  input  logic                            capture_i,
  input  logic [AXI_DATA_WIDTH-1:0]       rdata_i,
  input  logic [1:0]                      rresp_i,
  input  logic                            rlast_i,
  output logic [AXI_DATA_WIDTH*BEATS-1:0] row_o,
  output logic                            row_full_o,
  output logic                            err_o
);

  localparam int             BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  logic [BCW-1:0]                  beat_q, beat_d;
  logic [AXI_DATA_WIDTH*BEATS-1:0] row_q, row_d;
  logic                            last_beat;

  assign last_beat = (beat_q == LAST_BEAT);

  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (capture_i) begin
      row_d[int'(beat_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rdata_i;
      beat_d = last_beat ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

  // rlast must coincide exactly with the final beat; the burst length is fixed.
  assign row_full_o = capture_i && last_beat;
  assign err_o      = capture_i && ((rresp_i != AXI_RESP_OKAY) || (rlast_i != last_beat));
  assign row_o      = row_q;

endmodule
`default_nettype wire

// File: rtl/axi_master_unpacker.sv
`default_nettype none
// ============================================================================
// axi_master_unpacker : DDR-to-SRAM load engine, one AXI INCR burst per row
// Rev 1.0
// ============================================================================
module axi_master_unpacker
  import tensor_axi_pkg::*;
#(
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ARRAY_WIDTH     = 16,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_load,
  output logic                       load_done_irq,
  output logic                       load_err,
  input  logic [63:0]                reg_ddr_addr,
  input  logic [31:0]                reg_m_len,
  input  logic [31:0]                reg_addr_a,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data [ARRAY_WIDTH],
  output logic [31:0]                araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [AXI_DATA_WIDTH-1:0]  rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int         ROW_W     = SRAM_DATA_WIDTH * ARRAY_WIDTH;
  localparam int         BEATS     = ROW_W / AXI_DATA_WIDTH;
  localparam logic [7:0] ARLEN_VAL = 8'(BEATS - 1);

  unpacker_state_t       state_q, state_d;
  logic [31:0]           ddr_addr_q, ddr_addr_d;
  logic [31:0]           m_len_q, m_len_d;
  logic [31:0]           row_cnt_q, row_cnt_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;
  logic                  ar_hs, r_hs, start_ok, last_row;
  logic                  row_full, beat_err;
  logic [ROW_W-1:0]      row;
  logic                  w_unused_bits;

  assign ar_hs    = arvalid && arready;
  assign r_hs     = rvalid && rready;
  assign start_ok = (state_q == IDLE) && start_load;
  assign last_row = (row_cnt_q + 32'd1) >= m_len_q;

  axi_beat_assembler #(
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .BEATS          (BEATS)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (ar_hs),
    .capture_i  (r_hs),
    .rdata_i    (rdata),
    .rresp_i    (rresp),
    .rlast_i    (rlast),
    .row_o      (row),
    .row_full_o (row_full),
    .err_o      (beat_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start_load && (reg_m_len != 32'd0)) state_d = AXI_AR;
      AXI_AR:     if (arready) state_d = AXI_R;
      AXI_R:      if (row_full) state_d = SRAM_WR;
      SRAM_WR:    state_d = CHECK_DONE;
      CHECK_DONE: state_d = last_row ? IDLE : AXI_AR;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    arlen   = '0;
    rready  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      AXI_AR: begin
        arvalid = 1'b1;
        arlen   = ARLEN_VAL;
      end
      AXI_R:   rready = 1'b1;
      SRAM_WR: wr_en  = 1'b1;
      default: ;
    endcase
  end

  // Misaligned bases are flagged but still serviced from the row boundary below.
  always_comb begin
    ddr_addr_d  = ddr_addr_q;
    m_len_d     = m_len_q;
    row_cnt_d   = row_cnt_q;
    sram_addr_d = sram_addr_q;
    err_d       = err_q;
    irq_d       = 1'b0;
    if (start_ok) begin
      ddr_addr_d  = {reg_ddr_addr[31:6], 6'b0};
      sram_addr_d = reg_addr_a[ADDR_WIDTH-1:0];
      m_len_d     = reg_m_len;
      row_cnt_d   = '0;
      err_d       = |reg_ddr_addr[5:0];
      irq_d       = (reg_m_len == 32'd0);
    end
    if (beat_err) begin
      err_d = 1'b1;
    end
    if (state_q == CHECK_DONE) begin
      ddr_addr_d  = ddr_addr_q + ROW_STRIDE_BYTES;
      sram_addr_d = sram_addr_q + 1'b1;
      row_cnt_d   = row_cnt_q + 32'd1;
      irq_d       = last_row;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ddr_addr_q  <= '0;
      m_len_q     <= '0;
      row_cnt_q   <= '0;
      sram_addr_q <= '0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ddr_addr_q  <= ddr_addr_d;
      m_len_q     <= m_len_d;
      row_cnt_q   <= row_cnt_d;
      sram_addr_q <= sram_addr_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
    end
  end

  assign araddr        = ddr_addr_q;
  assign arsize        = AXI_SIZE_8B;
  assign arburst       = AXI_BURST_INCR;
  assign wr_addr       = sram_addr_q;
  assign load_err      = err_q;
  assign load_done_irq = irq_q;

  for (genvar gi = 0; gi < ARRAY_WIDTH; gi++) begin : g_elem
    assign wr_data[gi] = row[(gi+1)*SRAM_DATA_WIDTH-1 -: SRAM_DATA_WIDTH];
  end

  assign w_unused_bits = ^{reg_ddr_addr[63:32], reg_addr_a[31:ADDR_WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_axi_master_unpacker.sv
`default_nettype none
// ============================================================================
// tb_axi_master_unpacker : randomized AXI slave + DDR model, self-checking
// Rev 1.0
// ============================================================================
module tb_axi_master_unpacker;

  logic        clk, rst, start_load;
  logic        load_done_irq, load_err;
  logic [63:0] reg_ddr_addr;
  logic [31:0] reg_m_len, reg_addr_a;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data [16];
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  axi_master_unpacker #(
    .AXI_DATA_WIDTH(64), .SRAM_DATA_WIDTH(32), .ARRAY_WIDTH(16), .ADDR_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .start_load(start_load),
    .load_done_irq(load_done_irq), .load_err(load_err),
    .reg_ddr_addr(reg_ddr_addr), .reg_m_len(reg_m_len), .reg_addr_a(reg_addr_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int checks = 0, failures = 0;

  // Test-owned configuration of the slave/DDR model
  int          data_mode, gap_pct, ar_delay, err_row, err_beat, rlast_pos, tb_epoch;
  logic [31:0] inc_base, salt;

  // Slave/monitor-owned state
  bit          r_active, r_hs_pend, ar_hs_pend, prev_arv, prev_hs;
  int          r_beat, r_row, ar_wait, seen_epoch;
  logic [31:0] r_base, ar_addr_pend, prev_araddr;
  logic [31:0] ar_addr_q[$];
  int          ar_len_q[$];
  int          wq_addr[$];
  logic [511:0] wq_data[$];
  int          irq_cnt, irq_cyc, arv_cycles, stab_viol;

  // DDR contents as a pure function of byte address
  function automatic logic [63:0] ddr_word(input logic [31:0] a);
    logic [31:0] idx;
    if (data_mode == 0) begin
      idx = (a - inc_base) >> 3;
      return {32'h0, idx + 32'd1};
    end
    return {(a * 32'h9E37_79B1) ^ salt, (~a) ^ {salt[15:0], salt[31:16]}};
  endfunction

  // Element i of a row lives at byte offset 4*i of that row's DDR block
  function automatic logic [511:0] exp_row(input logic [31:0] base, input int r);
    logic [511:0] v;
    logic [63:0]  w;
    logic [31:0]  off;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      off = 32'(4 * i);
      w = ddr_word(base + 32'(r) * 32'h40 + (off & ~32'h7));
      v[i*32 +: 32] = off[2] ? w[63:32] : w[31:0];
    end
    return v;
  endfunction

  function automatic logic [511:0] flat_wr();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = wr_data[i];
    return v;
  endfunction

  // AXI slave + monitor, all decisions taken on the falling edge
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    seen_epoch = 0;
    forever begin
      @(negedge clk);
      if (tb_epoch != seen_epoch) begin
        seen_epoch = tb_epoch;
        r_active = 0; r_hs_pend = 0; ar_hs_pend = 0; ar_wait = 0; r_row = 0; r_beat = 0;
        rvalid = 1'b0; arready = 1'b0; rlast = 1'b0; rresp = 2'b00;
        ar_addr_q.delete(); ar_len_q.delete(); wq_addr.delete(); wq_data.delete();
        irq_cnt = 0; arv_cycles = 0; stab_viol = 0; prev_arv = 0; prev_hs = 0;
      end
      if (!rst) begin
        if (arvalid) arv_cycles++;
        if (prev_arv && !prev_hs && (!arvalid || araddr !== prev_araddr)) stab_viol++;
        if (wr_en) begin
          wq_addr.push_back(int'(wr_addr));
          wq_data.push_back(flat_wr());
        end
        if (load_done_irq) begin
          irq_cnt++;
          irq_cyc = cyc;
        end
        if (r_hs_pend) begin
          r_beat++; rvalid = 1'b0; r_hs_pend = 0;
          if (r_beat == 8) begin r_active = 0; r_row++; end
        end
        if (ar_hs_pend) begin
          r_active = 1; r_beat = 0; r_base = ar_addr_pend; ar_hs_pend = 0;
        end
        if (r_active) begin
          if (!rvalid) rvalid = ($urandom_range(0, 99) >= gap_pct);
          if (rvalid) begin
            rdata = ddr_word(r_base + 32'(8 * r_beat));
            rresp = (r_row == err_row && r_beat == err_beat) ? 2'b10 : 2'b00;
            rlast = (r_beat == rlast_pos);
            r_hs_pend = rready;
          end
        end else begin
          rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        end
        arready = 1'b0;
        if (arvalid) begin
          if (ar_wait >= ar_delay) begin
            arready = 1'b1; ar_hs_pend = 1; ar_addr_pend = araddr; ar_wait = 0;
            ar_addr_q.push_back(araddr);
            ar_len_q.push_back(int'(arlen));
          end else begin
            ar_wait++;
          end
        end
        prev_arv = arvalid; prev_hs = arvalid && arready; prev_araddr = araddr;
      end
    end
  end

  task automatic set_cfg(input int mode, input int gap, input int dly, input int erow,
                         input int ebeat, input int lpos);
    data_mode = mode; gap_pct = gap; ar_delay = dly;
    err_row = erow; err_beat = ebeat; rlast_pos = lpos;
    salt = $urandom;
  endtask

  task automatic do_load(input logic [31:0] base, input logic [31:0] mlen,
                         input logic [31:0] addra, input bit noise,
                         output int lat, output bit timed_out);
    int c0;
    @(negedge clk); #1;
    tb_epoch++;
    reg_ddr_addr = {32'hDEAD_BEEF, base}; reg_m_len = mlen; reg_addr_a = addra;
    start_load = 1'b1; c0 = cyc;
    @(negedge clk); #1;
    start_load = 1'b0;
    timed_out = 1;
    for (int k = 0; k < 3000; k++) begin
      if (irq_cnt > 0) begin timed_out = 0; break; end
      if (noise && (k % 7 == 3)) begin
        start_load = 1'b1; reg_ddr_addr = {$urandom, $urandom};
        reg_m_len = $urandom_range(5, 9); reg_addr_a = $urandom;
      end else begin
        start_load = 1'b0;
      end
      @(negedge clk); #1;
    end
    start_load = 1'b0;
    lat = irq_cyc - c0;
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({arvalid, rready, wr_en, load_done_irq, load_err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {arvalid, rready, wr_en, load_done_irq, load_err});
    end
    checks++;
    if (araddr !== 32'h0 || arlen !== 8'h0 || wr_addr !== 10'h0) begin
      failures++; $display("FAIL reset_addr araddr=%h arlen=%h wr_addr=%h exp all zero", araddr, arlen, wr_addr);
    end
    checks++;
    if (flat_wr() !== '0) begin
      failures++; $display("FAIL reset_wr_data got=%h exp=0", flat_wr());
    end
    checks++;
    if (arsize !== 3'b011 || arburst !== 2'b01) begin
      failures++; $display("FAIL reset_const arsize=%b arburst=%b exp 011/01", arsize, arburst);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit to; logic [511:0] d0;
    set_cfg(0, 0, 0, -1, -1, 7);
    inc_base = 32'h1000;
    do_load(32'h1000, 2, 5, 1'b0, lat, to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_irq exp=irq"); end
    checks++; if (lat != 23) begin failures++; $display("FAIL basic_irq_cycle got=%0d exp=23", lat); end
    checks++; if (irq_cnt != 1) begin failures++; $display("FAIL basic_irq_count got=%0d exp=1", irq_cnt); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", load_err); end
    checks++; if (arv_cycles != 2) begin failures++; $display("FAIL basic_arvalid_cycles got=%0d exp=2", arv_cycles); end
    checks++; if (ar_addr_q.size() != 2) begin failures++; $display("FAIL basic_ar_count got=%0d exp=2", ar_addr_q.size()); end
    for (int r = 0; r < ar_addr_q.size(); r++) begin
      checks++;
      if (ar_addr_q[r] !== 32'h1000 + 32'(r) * 32'h40 || ar_len_q[r] != 7) begin
        failures++; $display("FAIL basic_ar%0d addr=%h len=%0d exp addr=%h len=7", r, ar_addr_q[r], ar_len_q[r], 32'h1000 + 32'(r) * 32'h40);
      end
    end
    checks++; if (wq_addr.size() != 2) begin failures++; $display("FAIL basic_wr_count got=%0d exp=2", wq_addr.size()); end
    for (int r = 0; r < wq_addr.size(); r++) begin
      checks++;
      if (wq_addr[r] != 5 + r || wq_data[r] !== exp_row(32'h1000, r)) begin
        failures++; $display("FAIL basic_row%0d addr=%0d data=%h exp addr=%0d data=%h", r, wq_addr[r], wq_data[r], 5 + r, exp_row(32'h1000, r));
      end
    end
    d0 = (wq_data.size() > 0) ? wq_data[0] : '0;
    checks++; if (d0[31:0] !== 32'd1) begin failures++; $display("FAIL basic_elem0 got=%h exp=00000001", d0[31:0]); end
  endtask

  task automatic test_backpressure();
    int lat; bit to;
    set_cfg(0, 50, 3, -1, -1, 7);
    inc_base = 32'h1000;
    do_load(32'h1000, 2, 5, 1'b0, lat, to);
    checks++; if (to || irq_cnt != 1) begin failures++; $display("FAIL bp_irq got=%0d timeout=%0d exp=1", irq_cnt, to); end
    checks++; if (lat < 29) begin failures++; $display("FAIL bp_latency got=%0d exp>=29", lat); end
    checks++; if (stab_viol != 0) begin failures++; $display("FAIL bp_ar_stable got=%0d exp=0", stab_viol); end
    checks++; if (arv_cycles != 8) begin failures++; $display("FAIL bp_arvalid_cycles got=%0d exp=8", arv_cycles); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL bp_err got=%b exp=0", load_err); end
    checks++; if (wq_addr.size() != 2) begin failures++; $display("FAIL bp_wr_count got=%0d exp=2", wq_addr.size()); end
    for (int r = 0; r < wq_addr.size(); r++) begin
      checks++;
      if (wq_addr[r] != 5 + r || wq_data[r] !== exp_row(32'h1000, r)) begin
        failures++; $display("FAIL bp_row%0d addr=%0d data=%h exp addr=%0d data=%h", r, wq_addr[r], wq_data[r], 5 + r, exp_row(32'h1000, r));
      end
    end
  endtask

  task automatic test_slverr();
    int lat; bit to; logic [31:0] b;
    b = $urandom & 32'hFFFF_FFC0;
    set_cfg(1, 20, 1, 0, 3, 7);
    do_load(b, 1, 40, 1'b0, lat, to);
    checks++; if (to || irq_cnt != 1) begin failures++; $display("FAIL slverr_irq got=%0d exp=1", irq_cnt); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL slverr_err got=%b exp=1", load_err); end
    checks++;
    if (wq_addr.size() != 1 || wq_data[0] !== exp_row(b, 0)) begin
      failures++; $display("FAIL slverr_write count=%0d exp count=1 with model row", wq_addr.size());
    end
    set_cfg(1, 0, 0, -1, -1, 2);
    do_load(b, 1, 41, 1'b0, lat, to);
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL rlast_err got=%b exp=1", load_err); end
    checks++; if (wq_addr.size() != 1) begin failures++; $display("FAIL rlast_write count=%0d exp=1", wq_addr.size()); end
    set_cfg(1, 0, 0, -1, -1, 7);
    do_load(b, 1, 42, 1'b0, lat, to);
    checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", load_err); end
  endtask

  task automatic test_zero_len();
    int lat; bit to;
    set_cfg(0, 0, 0, -1, -1, 7);
    do_load(32'h2000, 0, 3, 1'b0, lat, to);
    checks++; if (to || lat != 1) begin failures++; $display("FAIL zero_irq_cycle got=%0d exp=1", lat); end
    checks++; if (irq_cnt != 1) begin failures++; $display("FAIL zero_irq_count got=%0d exp=1", irq_cnt); end
    checks++; if (arv_cycles != 0) begin failures++; $display("FAIL zero_arvalid got=%0d exp=0", arv_cycles); end
    checks++; if (wq_addr.size() != 0) begin failures++; $display("FAIL zero_wr got=%0d exp=0", wq_addr.size()); end
  endtask

  task automatic test_wrap_misalign();
    int lat; bit to;
    set_cfg(1, 30, 2, -1, -1, 7);
    do_load(32'h1004, 2, 1023, 1'b0, lat, to);
    checks++; if (to || irq_cnt != 1) begin failures++; $display("FAIL wrap_irq got=%0d exp=1", irq_cnt); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("FAIL misalign_err got=%b exp=1", load_err); end
    checks++;
    if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 32'h1000 || ar_addr_q[1] !== 32'h1040) begin
      failures++; $display("FAIL misalign_araddr count=%0d first=%h exp 2 ARs at 1000,1040", ar_addr_q.size(), (ar_addr_q.size() > 0) ? ar_addr_q[0] : 32'h0);
    end
    checks++; if (wq_addr.size() != 2) begin failures++; $display("FAIL wrap_wr_count got=%0d exp=2", wq_addr.size()); end
    for (int r = 0; r < wq_addr.size(); r++) begin
      checks++;
      if (wq_addr[r] != (1023 + r) % 1024 || wq_data[r] !== exp_row(32'h1000, r)) begin
        failures++; $display("FAIL wrap_row%0d addr=%0d exp=%0d data=%h exp=%h", r, wq_addr[r], (1023 + r) % 1024, wq_data[r], exp_row(32'h1000, r));
      end
    end
  endtask

  task automatic test_reset_midburst();
    int lat; bit to, hit; logic [31:0] b;
    set_cfg(1, 0, 0, -1, -1, 7);
    b = $urandom & 32'hFFFF_FFC0;
    @(negedge clk); #1;
    tb_epoch++;
    reg_ddr_addr = {32'h0, b}; reg_m_len = 3; reg_addr_a = 7; start_load = 1'b1;
    @(negedge clk); #1;
    start_load = 1'b0;
    hit = 0;
    for (int k = 0; k < 200; k++) begin
      if (r_active && r_beat == 4 && rvalid) begin hit = 1; break; end
      @(negedge clk); #1;
    end
    checks++; if (!hit) begin failures++; $display("FAIL midrst_reach got=no_beat4 exp=beat4"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({arvalid, rready, wr_en, load_done_irq, load_err} !== 5'b0 || araddr !== 32'h0 ||
        arlen !== 8'h0 || wr_addr !== 10'h0 || flat_wr() !== '0) begin
      failures++; $display("FAIL midrst_outputs ctrl=%b araddr=%h wr_addr=%h exp all zero",
                           {arvalid, rready, wr_en, load_done_irq, load_err}, araddr, wr_addr);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    tb_epoch++;
    b = $urandom & 32'hFFFF_FFC0;
    do_load(b, 2, 300, 1'b1, lat, to);
    checks++; if (to || irq_cnt != 1) begin failures++; $display("FAIL busy_irq got=%0d exp=1", irq_cnt); end
    checks++; if (ar_addr_q.size() != 2) begin failures++; $display("FAIL busy_ar_count got=%0d exp=2", ar_addr_q.size()); end
    checks++; if (wq_addr.size() != 2) begin failures++; $display("FAIL busy_wr_count got=%0d exp=2", wq_addr.size()); end
    for (int r = 0; r < wq_addr.size(); r++) begin
      checks++;
      if (wq_addr[r] != 300 + r || wq_data[r] !== exp_row(b, r)) begin
        failures++; $display("FAIL busy_row%0d addr=%0d exp=%0d", r, wq_addr[r], 300 + r);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit to; logic [31:0] b, ea; int m, a;
    for (int it = 0; it < 5; it++) begin
      set_cfg(1, $urandom_range(0, 60), $urandom_range(0, 4), -1, -1, 7);
      b = (it == 0) ? 32'hFFFF_FF80 : ($urandom & 32'hFFFF_FFC0);
      m = (it == 0) ? 3 : $urandom_range(1, 4);
      a = $urandom_range(0, 1023);
      do_load(b, 32'(m), 32'(a), 1'b0, lat, to);
      checks++; if (to || irq_cnt != 1) begin failures++; $display("FAIL rnd%0d_irq got=%0d exp=1", it, irq_cnt); end
      checks++; if (load_err !== 1'b0) begin failures++; $display("FAIL rnd%0d_err got=%b exp=0", it, load_err); end
      checks++; if (stab_viol != 0) begin failures++; $display("FAIL rnd%0d_ar_stable got=%0d exp=0", it, stab_viol); end
      checks++; if (ar_addr_q.size() != m) begin failures++; $display("FAIL rnd%0d_ar_count got=%0d exp=%0d", it, ar_addr_q.size(), m); end
      for (int r = 0; r < ar_addr_q.size(); r++) begin
        ea = b + 32'(r) * 32'h40;
        checks++;
        if (ar_addr_q[r] !== ea) begin failures++; $display("FAIL rnd%0d_ar%0d got=%h exp=%h", it, r, ar_addr_q[r], ea); end
      end
      checks++; if (wq_addr.size() != m) begin failures++; $display("FAIL rnd%0d_wr_count got=%0d exp=%0d", it, wq_addr.size(), m); end
      for (int r = 0; r < wq_addr.size(); r++) begin
        checks++;
        if (wq_addr[r] != (a + r) % 1024 || wq_data[r] !== exp_row(b, r)) begin
          failures++; $display("FAIL rnd%0d_row%0d addr=%0d exp=%0d data=%h exp=%h", it, r, wq_addr[r], (a + r) % 1024, wq_data[r], exp_row(b, r));
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_load = 1'b0;
    reg_ddr_addr = '0; reg_m_len = '0; reg_addr_a = '0;
    tb_epoch = 0; inc_base = 32'h0;
    set_cfg(0, 0, 0, -1, -1, 7);
    test_reset();
    test_basic();
    test_backpressure();
    test_slverr();
    test_zero_len();
    test_wrap_misalign();
    test_reset_midburst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
